// File: rtl/cpu_datapath_pkg.sv
// cpu_datapath_pkg: definitions shared by the CPU controller and datapath.
//   - opcode_e   : 4-bit instruction opcodes (IR[7:4])
//   - sel_acc_e  : ACC source select encodings
//   - Ir*        : instruction field bit positions
//   - jump_cond(): whether a conditional-jump opcode fires for the given flags
package cpu_datapath_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpNor  = 4'h3,
    OpMovr = 4'h4,
    OpMova = 4'h5,
    OpJzrs = 4'h6,
    OpJzim = 4'h7,
    OpJcrs = 4'h8,
    OpJcim = 4'hA,
    OpShl  = 4'hB,
    OpShr  = 4'hC,
    OpLdim = 4'hD,
    OpHalt = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    SelAccAlu = 2'b00,
    SelAccRsv = 2'b01,
    SelAccReg = 2'b10,
    SelAccImm = 2'b11
  } sel_acc_e;

  localparam int unsigned IrOpMsb  = 7;
  localparam int unsigned IrOpLsb  = 4;
  localparam int unsigned IrFldMsb = 3;
  localparam int unsigned IrFldLsb = 0;

  // Only the four conditional jumps can redirect the PC; every other opcode ignores LoadPC.
  function automatic logic jump_cond(input logic [3:0] op, input logic z, input logic c);
    logic taken;
    taken = 1'b0;
    case (op)
      OpJzrs, OpJzim: taken = z;
      OpJcrs, OpJcim: taken = c;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU of the CPU datapath.
//   i_acc         : accumulator operand A
//   i_b           : register operand B
//   i_sel         : function select, opcode encoding
//   o_r           : result
//   o_carry       : carry / borrow / shifted-out bit
//   o_carry_valid : 1 when o_carry should update the C flag
module cpu_alu
  import cpu_datapath_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic [DW-1:0] i_acc,
  input  logic [DW-1:0] i_b,
  input  logic [3:0]    i_sel,
  output logic [DW-1:0] o_r,
  output logic          o_carry,
  output logic          o_carry_valid
);

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;

  assign w_sum  = {1'b0, i_acc} + {1'b0, i_b};
  // MSB of the widened difference is the borrow, i.e. i_acc < i_b.
  assign w_diff = {1'b0, i_acc} - {1'b0, i_b};

  always_comb begin
    o_r           = i_acc;
    o_carry       = 1'b0;
    o_carry_valid = 1'b0;
    case (i_sel)
      OpAdd: begin
        o_r           = w_sum[DW-1:0];
        o_carry       = w_sum[DW];
        o_carry_valid = 1'b1;
      end
      OpSub: begin
        o_r           = w_diff[DW-1:0];
        o_carry       = w_diff[DW];
        o_carry_valid = 1'b1;
      end
      OpNor: begin
        o_r           = ~(i_acc | i_b);
        o_carry       = 1'b0;
        o_carry_valid = 1'b1;
      end
      OpShl: begin
        o_r           = {i_acc[DW-2:0], 1'b0};
        o_carry       = i_acc[DW-1];
        o_carry_valid = 1'b1;
      end
      OpShr: begin
        o_r           = {1'b0, i_acc[DW-1:1]};
        o_carry       = i_acc[0];
        o_carry_valid = 1'b1;
      end
      default: begin
        // Pass-through; carry left untouched.
        o_r           = i_acc;
        o_carry       = 1'b0;
        o_carry_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: datapath half of the CPU. Holds PC, IR, ACC, Z/C flags and a
// 16-entry register file; executes the controller strobes each clock.
//   clk        : clock, all state on posedge
//   CLB        : synchronous active-high reset, overrides every strobe
//   LoadIR     : IR <= imem_data
//   IncPC      : PC <= PC + 1 (when no jump is taken)
//   SelPC      : jump target, 1 = Reg[IR[3:0]], 0 = IR[3:0]
//   LoadPC     : conditional jump strobe
//   LoadReg    : Reg[IR[3:0]] <= ACC
//   LoadAcc    : ACC write strobe
//   SelAcc     : ACC source (00 ALU, 10 register, 11 immediate, 01 no write)
//   SelALU     : ALU function
//   imem_addr  : instruction address (= PC)
//   imem_data  : instruction word at imem_addr, same cycle
//   op         : IR opcode field
//   z, c       : zero / carry flags
//   acc_out    : ACC for debug
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int unsigned DW   = 4,
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            CLB,
  input  logic            LoadIR,
  input  logic            IncPC,
  input  logic            SelPC,
  input  logic            LoadPC,
  input  logic            LoadReg,
  input  logic            LoadAcc,
  input  logic [1:0]      SelAcc,
  input  logic [3:0]      SelALU,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  output logic [3:0]      op,
  output logic            z,
  output logic            c,
  output logic [DW-1:0]   acc_out
);

  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [DW-1:0]   r_acc;
  logic            r_z;
  logic            r_c;
  logic [DW-1:0]   r_regs [16];

  logic [3:0]      w_op;
  logic [3:0]      w_fld;
  logic [DW-1:0]   w_b;
  logic            w_taken;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_next;
  logic [DW-1:0]   w_alu_r;
  logic            w_alu_c;
  logic            w_alu_cv;
  logic            w_acc_we;
  logic [DW-1:0]   w_acc_next;
  logic            w_c_next;
  logic            w_z_next;

  assign w_op  = r_ir[IrOpMsb:IrOpLsb];
  assign w_fld = r_ir[IrFldMsb:IrFldLsb];
  // Register-file read sees pre-write contents: no bypass from LoadReg.
  assign w_b   = r_regs[w_fld];

  cpu_alu #(
    .DW(DW)
  ) u_alu (
    .i_acc         (r_acc),
    .i_b           (w_b),
    .i_sel         (SelALU),
    .o_r           (w_alu_r),
    .o_carry       (w_alu_c),
    .o_carry_valid (w_alu_cv)
  );

  // Jumps use the registered flags, never this cycle's ALU result.
  assign w_taken  = LoadPC && jump_cond(w_op, r_z, r_c);
  assign w_target = SelPC ? PC_W'(w_b) : PC_W'(w_fld);

  always_comb begin
    w_pc_next = r_pc;
    if (w_taken) begin
      w_pc_next = w_target;
    end else if (IncPC) begin
      w_pc_next = r_pc + PC_W'(1);
    end
  end

  always_comb begin
    w_acc_we   = 1'b0;
    w_acc_next = r_acc;
    w_c_next   = r_c;
    if (LoadAcc) begin
      case (SelAcc)
        SelAccAlu: begin
          w_acc_we   = 1'b1;
          w_acc_next = w_alu_r;
          if (w_alu_cv) begin
            w_c_next = w_alu_c;
          end
        end
        SelAccReg: begin
          w_acc_we   = 1'b1;
          w_acc_next = w_b;
        end
        SelAccImm: begin
          w_acc_we   = 1'b1;
          w_acc_next = DW'(w_fld);
        end
        default: begin
          // Reserved encoding: no write, flags hold.
          w_acc_we   = 1'b0;
          w_acc_next = r_acc;
        end
      endcase
    end
    w_z_next = w_acc_we ? (w_acc_next == '0) : r_z;
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_acc <= '0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pc  <= w_pc_next;
      r_acc <= w_acc_next;
      r_z   <= w_z_next;
      r_c   <= w_c_next;
      // IR captures the word at the pre-update PC.
      if (LoadIR) begin
        r_ir <= imem_data;
      end
      // Register gets the old ACC even if LoadAcc fires in the same cycle.
      if (LoadReg) begin
        r_regs[w_fld] <= r_acc;
      end
    end
  end

  assign imem_addr = r_pc;
  assign op        = w_op;
  assign z         = r_z;
  assign c         = r_c;
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed bench for cpu_datapath with an integer-arithmetic
// reference model updated each posedge and compared on every negedge.
module tb_cpu_datapath;

  localparam int DW   = 4;
  localparam int PC_W = 8;
  localparam int M    = 1 << DW;
  localparam int PM   = 1 << PC_W;

  logic            clk;
  logic            CLB;
  logic            LoadIR;
  logic            IncPC;
  logic            SelPC;
  logic            LoadPC;
  logic            LoadReg;
  logic            LoadAcc;
  logic [1:0]      SelAcc;
  logic [3:0]      SelALU;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_data;
  logic [3:0]      op;
  logic            z;
  logic            c;
  logic [DW-1:0]   acc_out;

  logic [7:0] mem [PM];

  int n_checks;
  int n_fail;
  bit chk_en;

  int m_pc, m_ir, m_acc, m_z, m_c;
  int m_regs [16];

  cpu_datapath #(
    .DW   (DW),
    .PC_W (PC_W)
  ) dut (
    .clk       (clk),
    .CLB       (CLB),
    .LoadIR    (LoadIR),
    .IncPC     (IncPC),
    .SelPC     (SelPC),
    .LoadPC    (LoadPC),
    .LoadReg   (LoadReg),
    .LoadAcc   (LoadAcc),
    .SelAcc    (SelAcc),
    .SelALU    (SelALU),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .op        (op),
    .z         (z),
    .c         (c),
    .acc_out   (acc_out)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural state.
  always @(posedge clk) begin : model
    int opc, fld, b, o_acc, o_pc, sum, nacc;
    bit taken, wr;
    if (CLB) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
    end else begin
      opc   = m_ir / 16;
      fld   = m_ir % 16;
      b     = m_regs[fld];
      o_acc = m_acc;
      o_pc  = m_pc;
      taken = LoadPC && ((((opc == 6) || (opc == 7)) && (m_z != 0)) ||
                         (((opc == 8) || (opc == 10)) && (m_c != 0)));
      if (LoadIR) m_ir = int'(mem[o_pc]);
      if (taken) m_pc = SelPC ? (b % PM) : fld;
      else if (IncPC) m_pc = (o_pc + 1) % PM;
      if (LoadReg) m_regs[fld] = o_acc;
      wr = 1'b0;
      if (LoadAcc) begin
        case (SelAcc)
          2'b00: begin
            wr = 1'b1;
            case (SelALU)
              4'd1: begin sum = o_acc + b; nacc = sum % M; m_c = (sum >= M) ? 1 : 0; end
              4'd2: begin nacc = (o_acc - b + M) % M; m_c = (o_acc < b) ? 1 : 0; end
              4'd3: begin nacc = (M - 1) - (o_acc | b); m_c = 0; end
              4'd11: begin nacc = (o_acc * 2) % M; m_c = (o_acc >= M / 2) ? 1 : 0; end
              4'd12: begin nacc = o_acc / 2; m_c = o_acc % 2; end
              default: nacc = o_acc;
            endcase
            m_acc = nacc;
          end
          2'b10: begin wr = 1'b1; m_acc = b; end
          2'b11: begin wr = 1'b1; m_acc = fld; end
          default: wr = 1'b0;
        endcase
        if (wr) m_z = (m_acc == 0) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",  int'(imem_addr), m_pc);
      chk("op",  int'(op), m_ir / 16);
      chk("acc", int'(acc_out), m_acc);
      chk("z",   int'(z), m_z);
      chk("c",   int'(c), m_c);
    end
  end

  task automatic cyc(input bit rst, input bit lir, input bit ipc, input bit spc, input bit lpc,
                     input bit lreg, input bit lacc, input bit [1:0] sacc, input bit [3:0] salu);
    CLB = rst; LoadIR = lir; IncPC = ipc; SelPC = spc; LoadPC = lpc;
    LoadReg = lreg; LoadAcc = lacc; SelAcc = sacc; SelALU = salu;
    @(posedge clk);
    #1;
    CLB = 0; LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0;
    LoadReg = 0; LoadAcc = 0; SelAcc = 2'b00; SelALU = 4'h0;
  endtask

  task automatic set_ir(input bit [7:0] v);
    mem[m_pc] = v;
    cyc(0, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0);
  endtask

  task automatic ldim(input bit [3:0] v);
    set_ir({4'hD, v});
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b11, 4'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    for (int i = 0; i < PM; i++) mem[i] = 8'h00;
    CLB = 1; LoadIR = 1; IncPC = 1; SelPC = 1; LoadPC = 1;
    LoadReg = 1; LoadAcc = 1; SelAcc = 2'b00; SelALU = 4'h1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0);
    chk("rst_pc", int'(imem_addr), 0);
    chk("rst_op", int'(op), 0);
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_zc", int'({z, c}), 0);
    chk_en = 1'b1;

    // LDIM 9, MOVA R2, ADD R2
    set_ir(8'hD9);
    chk("op_ldim", int'(op), 13);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b11, 4'h0);
    chk("ldim9", int'(acc_out), 9);
    set_ir(8'h52);
    cyc(0, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    set_ir(8'h12);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h1);
    chk("add_acc", int'(acc_out), 2);
    chk("add_zc", int'({z, c}), 1);

    // SUB / NOR / SHR / SHL chain
    ldim(4'h5);
    set_ir(8'h55);
    cyc(0, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    set_ir(8'h25);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h2);
    chk("sub_acc", int'(acc_out), 0);
    chk("sub_zc", int'({z, c}), 2);
    set_ir(8'h30);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b00, 4'h3);
    chk("nor_acc", int'(acc_out), 15);
    chk("nor_c", int'(c), 0);
    set_ir(8'hC0);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b00, 4'hC);
    chk("shr_acc", int'(acc_out), 7);
    chk("shr_c", int'(c), 1);
    set_ir(8'hB0);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b00, 4'hB);
    chk("shl_acc", int'(acc_out), 14);
    chk("shl_c", int'(c), 0);

    // Reserved SelAcc holds ACC
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b01, 4'h1);
    chk("rsv_acc", int'(acc_out), 14);

    // LoadReg + LoadAcc together: R7 gets old ACC
    set_ir(8'hD7);
    cyc(0, 0, 0, 0, 0, 1, 1, 2'b11, 4'h0);
    chk("sim_acc", int'(acc_out), 7);
    set_ir(8'h47);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0);
    chk("sim_r7", int'(acc_out), 14);

    // Same-cycle read of written register returns old value
    set_ir(8'h42);
    cyc(0, 0, 0, 0, 0, 1, 1, 2'b10, 4'h0);
    chk("nobyp_old", int'(acc_out), 9);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0);
    chk("nobyp_new", int'(acc_out), 14);

    // Conditional jumps
    ldim(4'h0);
    set_ir(8'h7A);
    cyc(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'h0);
    chk("jzim_taken", int'(imem_addr), 8'h0A);
    ldim(4'h1);
    set_ir(8'h7A);
    cyc(0, 0, 1, 0, 1, 0, 0, 2'b00, 4'h0);
    chk("jzim_not", int'(imem_addr), 8'h0B);
    ldim(4'h6);
    set_ir(8'h53);
    cyc(0, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0);
    ldim(4'hF);
    set_ir(8'hB0);
    cyc(0, 0, 0, 0, 0, 0, 1, 2'b00, 4'hB);
    chk("shl_c1", int'(c), 1);
    set_ir(8'h83);
    cyc(0, 0, 0, 1, 1, 0, 0, 2'b00, 4'h0);
    chk("jcrs_taken", int'(imem_addr), 8'h06);

    // PC wrap with simultaneous fetch
    for (int i = 0; i < 249; i++) cyc(0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0);
    chk("pc_ff", int'(imem_addr), 8'hFF);
    mem[8'hFF] = 8'hAB;
    cyc(0, 1, 1, 0, 0, 0, 0, 2'b00, 4'h0);
    chk("wrap_op", int'(op), 4'hA);
    chk("wrap_pc", int'(imem_addr), 0);

    // Reset in the middle of an ALU write plus register write
    ldim(4'h3);
    set_ir(8'h12);
    cyc(1, 1, 1, 0, 0, 1, 1, 2'b00, 4'h1);
    chk("mid_acc", int'(acc_out), 0);
    chk("mid_zc", int'({z, c}), 0);
    chk("mid_op", int'(op), 0);
    for (int i = 0; i < 16; i++) begin
      set_ir(8'h40 | 8'(i));
      cyc(0, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0);
      chk("reg_clr", int'(acc_out), 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath end of the CPU control interface: holds PC, IR, ACC, a 16-entry register file, Z/C flags and the ALU.
- Consumes the controller strobes (LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU).
- Returns op, z and c to the controller.
- Drives the instruction-memory address and reads the 8-bit instruction combinationally.

Parameters:
- DW, 4, ACC/register/ALU data width (must be >= 4).
- PC_W, 8, PC and instruction-address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- CLB  in  1  reset; synchronous, active-high.
- LoadIR  in  1  IR <= imem_data.
- IncPC  in  1  PC <= PC+1.
- SelPC  in  1  jump target select: 1 = Reg[IR[3:0]], 0 = IR[3:0]; both zero-extended to PC_W.
- LoadPC  in  1  conditional jump strobe.
- LoadReg  in  1  Reg[IR[3:0]] <= ACC.
- LoadAcc  in  1  ACC write strobe.
- SelAcc  in  2  ACC source: 00 ALU, 10 Reg[IR[3:0]], 11 immediate IR[3:0], 01 reserved.
- SelALU  in  4  ALU function (opcode encoding).
- imem_addr  out  PC_W  equals PC.
- imem_data  in  8  instruction at imem_addr, same cycle.
- op  out  4  IR[7:4].
- z  out  1  zero flag.
- c  out  1  carry flag.
- acc_out  out  DW  ACC, for debug.

Behaviour:
- Instruction format: [7:4] opcode, [3:0] field (register index or immediate).
- Reset (CLB=1 at posedge) sets:
  - PC=0, IR=0 (NOP), ACC=0, z=0, c=0.
  - All 16 registers = 0.
- Reset overrides every strobe in the same cycle. Reset mid-instruction discards the instruction.
- IR: on LoadIR, IR <= imem_data. One-cycle latency; op is valid the cycle after.
- PC update priority:
  - Jump taken: PC <= target.
  - Jump not taken, or no LoadPC: if IncPC, PC <= PC+1, wrapping 2^PC_W-1 -> 0.
  - Otherwise PC holds.
- Jump condition, evaluated on current op:
  - JZRS (0110) and JZIM (0111) jump if z=1.
  - JCRS (1000) and JCIM (1010) jump if c=1.
  - Any other op with LoadPC: no jump.
- LoadIR and PC update may occur in the same cycle. IR captures the pre-update PC's word.
- ALU is combinational on ACC, operand B = Reg[IR[3:0]], function SelALU:
  - ADD 0001: {c,r} = ACC+B.
  - SUB 0010: r = ACC-B; c = borrow (ACC<B).
  - NOR 0011: r = ~(ACC|B); c = 0.
  - SHL 1011: r = ACC<<1; c = ACC[DW-1].
  - SHR 1100: r = ACC>>1 (logical); c = ACC[0].
  - Other codes: r = ACC; c unchanged.
- ACC write on LoadAcc:
  - SelAcc 00: ACC <= r, c <= ALU carry.
  - SelAcc 10: ACC <= Reg[IR[3:0]], c unchanged.
  - SelAcc 11: ACC <= zero-extended IR[3:0], c unchanged.
  - SelAcc 01: ACC and c hold, z holds.
  - For every write, z <= (new ACC == 0).
- Register write: on LoadReg, Reg[IR[3:0]] <= ACC.
  - A same-cycle read of that register returns the old value; no bypass.
- Simultaneous LoadReg and LoadAcc: both occur. The register gets the old ACC.
- Flags change only on LoadAcc writes. Jumps read the registered flags.

Decomposition:
- Shared include cpu_defs.vh holds:
  - The 14 opcode constants (NOP 0000 … HALT 1111, JCIM 1010).
  - SelAcc encodings.
  - The instruction field bit positions.
- The controller and datapath both include it.
- One sub-module, cpu_alu: combinational (ACC, B, SelALU) -> (r, carry_out, carry_valid).
- PC, IR, ACC, flags and the register file stay in cpu_datapath.

Test Plan:
- Reset: hold CLB=1 two cycles with all strobes high -> PC=0, IR=0, ACC=0, z=0, c=0, all registers 0.
- LDIM/MOVA/ADD: IR=0xD9, LoadAcc, SelAcc=11 -> ACC=9. MOVA to R2 (LoadReg) -> R2=9. ADD R2 (SelAcc=00, SelALU=0001) -> ACC=2, c=1, z=0.
- SUB/NOR/shift flags, each step from the previous result:
  - ACC=5 SUB R(=5) -> ACC=0, z=1, c=0.
  - NOR R(=0) -> ACC=F, c=0.
  - SHR -> ACC=7, c=1.
  - SHL -> ACC=E, c=0.
- Conditional jumps:
  - JZIM 0x7A with z=1, LoadPC, SelPC=0 -> PC=0x0A.
  - Same with z=0 and IncPC=1 -> PC=PC+1.
  - JCRS 0x83 with c=1, R3=6, SelPC=1 -> PC=0x06.
- PC wrap and fetch: PC=0xFF, IncPC with LoadIR -> IR = word at 0xFF, PC=0x00.
- Reset mid-op: assert CLB during a LoadAcc with SelAcc=00 -> ACC=0, flags 0, no register modified.
